bin8_bcd_7seg_mux: RTL and testbench



---
 rtl/bin8_bcd_7seg_mux.sv | 208 ++++++++++++++++++++
 tb/tb_bin8_bcd_7seg_mux.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bin8_bcd_7seg_mux.sv
`default_nettype none
// ============================================================================
// Module   : bin8_bcd_7seg_mux
// Purpose  : Shows an 8-bit binary value as three decimal digits on a
//            multiplexed common-anode 7-segment display. A sequential
//            double-dabble converter (one bit per cycle, 8 cycles) runs
//            whenever the input differs from the last converted value. A scan
//            divider lights hundreds, tens and ones in turn on a shared
//            segment bus.
// Ports    : clk        system clock, rising edge
//            rst        synchronous reset, active-high
//            value[7:0] binary value to display
//            seg[6:0]   segments, active-low, {g,f,e,d,c,b,a}
//            an[2:0]    digit enables, active-low (0=ones,1=tens,2=hundreds)
//            bcd[11:0]  last converted value {hundreds,tens,ones}
//            bcd_valid  one-cycle pulse when bcd updates
//            busy       high while a conversion is in progress
// Options  : define LEADING_ZERO_BLANK_EN to blank leading zero digits
//            (hundreds when 0, tens when hundreds and tens are both 0).
// Revision : 1.0 - initial release
// ============================================================================
module bin8_bcd_7seg_mux #(
    parameter int F_CLK_HZ   = 50_000_000,
    parameter int REFRESH_HZ = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  value,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic [11:0] bcd,
    output logic        bcd_valid,
    output logic        busy
);

    // ------------------------------------------------------------------------
    // Scan timing constants
    // ------------------------------------------------------------------------
    localparam int DIGIT_TICKS_RAW = F_CLK_HZ / (REFRESH_HZ * 3);
    localparam int DIGIT_TICKS     = (DIGIT_TICKS_RAW < 1) ? 1 : DIGIT_TICKS_RAW;
    localparam int DIV_W           = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIGIT_TICKS - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [2:0] AN_ONES   = 3'b110;
    localparam logic [2:0] AN_TENS   = 3'b101;
    localparam logic [2:0] AN_HUND   = 3'b011;

    // ------------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------------
    // Double-dabble correction: a nibble of 5 or more would overflow past 9
    // after the left shift, so bias it by 3 first.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        add3 = (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Converter FSM
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } conv_state_t;

    conv_state_t r_state;
    logic [7:0]  r_last_val;
    logic [7:0]  r_shreg;
    logic [11:0] r_acc;
    logic [2:0]  r_iter;

    logic [11:0] w_acc_adj;
    logic [11:0] w_acc_next;
    logic        w_unused;

    assign w_acc_adj  = {add3(r_acc[11:8]), add3(r_acc[7:4]), add3(r_acc[3:0])};
    // Shift the corrected accumulator left, pulling in the next binary MSB.
    assign w_acc_next = {w_acc_adj[10:0], r_shreg[7]};
    // The hundreds nibble never exceeds 2, so its top bit never carries out.
    assign w_unused   = w_acc_adj[11];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_last_val <= 8'd0;
            r_shreg    <= 8'd0;
            r_acc      <= 12'd0;
            r_iter     <= 3'd0;
            bcd        <= 12'h000;
            bcd_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    // value is sampled only here, so changes during SHIFT
                    // are caught by the first compare after returning.
                    if (value != r_last_val) begin
                        r_shreg    <= value;
                        r_last_val <= value;
                        r_acc      <= 12'd0;
                        r_iter     <= 3'd0;
                        busy       <= 1'b1;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_acc   <= w_acc_next;
                    r_shreg <= {r_shreg[6:0], 1'b0};
                    r_iter  <= r_iter + 3'd1;
                    if (r_iter == 3'd7) begin
                        bcd       <= w_acc_next;
                        bcd_valid <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Scan divider and digit multiplexer
    // ------------------------------------------------------------------------
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_idx;

    logic             w_div_wrap;
    logic [1:0]       w_idx_next;
    logic [3:0]       w_nib;
    logic             w_blank;
    logic [2:0]       w_an;
    logic [6:0]       w_seg;

    assign w_div_wrap = (r_div == DIV_LAST);

    always_comb begin
        w_idx_next = r_idx;
        if (w_div_wrap) begin
            w_idx_next = (r_idx >= 2'd2) ? 2'd0 : (r_idx + 2'd1);
        end
    end

    // Digit selection looks at the index the outputs are about to show, so
    // an and seg change together on the wrap edge.
    always_comb begin
        w_nib   = bcd[3:0];
        w_an    = AN_ONES;
        w_blank = 1'b0;
        case (w_idx_next)
            2'd1: begin
                w_nib = bcd[7:4];
                w_an  = AN_TENS;
            end
            2'd2: begin
                w_nib = bcd[11:8];
                w_an  = AN_HUND;
            end
            default: begin
                w_nib = bcd[3:0];
                w_an  = AN_ONES;
            end
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if ((w_idx_next == 2'd2) && (bcd[11:8] == 4'd0)) begin
            w_blank = 1'b1;
        end
        if ((w_idx_next == 2'd1) && (bcd[11:4] == 8'd0)) begin
            w_blank = 1'b1;
        end
`endif
        w_seg = w_blank ? SEG_BLANK : seg_decode(w_nib);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
            r_idx <= 2'd0;
            an    <= AN_ONES;
            seg   <= SEG_ZERO;
        end else begin
            r_div <= w_div_wrap ? '0 : (r_div + 1'b1);
            r_idx <= w_idx_next;
            an    <= w_an;
            seg   <= w_seg;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bin8_bcd_7seg_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin8_bcd_7seg_mux
// Purpose  : Self-checking bench for bin8_bcd_7seg_mux with DIGIT_TICKS=4.
//            Conversion results are tracked by a queue of expected bcd words
//            that is pushed when a value is driven and popped on bcd_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin8_bcd_7seg_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  value;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic [11:0] bcd;
    logic        bcd_valid;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [11:0] exp_q[$];

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'b1111111;
`else
    localparam logic [6:0] LZ = 7'b1000000;
`endif

    bin8_bcd_7seg_mux #(
        .F_CLK_HZ   (3000),
        .REFRESH_HZ (250)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .value     (value),
        .seg       (seg),
        .an        (an),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  v;
        logic [11:0] bcd;
        logic [6:0]  seg_h;
        logic [6:0]  seg_t;
        logic [6:0]  seg_o;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every bcd_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && bcd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_bcd_valid", 32'(bcd), 32'hFFFF_FFFF);
            end else begin
                chk("sb_bcd", 32'(bcd), 32'(exp_q.pop_front()));
            end
        end
    end

    function automatic logic [11:0] model_bcd(input int v);
        model_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Drive a new value and check the full conversion timeline.
    task automatic convert(input logic [7:0] v, input logic [11:0] exp);
        value = v;
        exp_q.push_back(exp);
        tick();
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 8) begin
                if (busy !== 1'b1 || bcd_valid !== 1'b0) begin
                    chk("busy_during_shift", {30'd0, busy, bcd_valid}, 32'b10);
                end
            end else begin
                chk("bcd_valid_at_n8", 32'(bcd_valid), 32'd1);
                chk("busy_low_at_n8", 32'(busy), 32'd0);
                chk("bcd_at_n8", 32'(bcd), 32'(exp));
            end
        end
        tick();
        chk("bcd_valid_single", 32'(bcd_valid), 32'd0);
    endtask

    // Align to the start of the ones digit and check one full 12-cycle scan.
    task automatic check_scan(input logic [6:0] sh, input logic [6:0] st, input logic [6:0] so);
        logic [2:0] prev;
        logic [2:0] exp_an [3];
        logic [6:0] exp_seg[3];
        bit         found;
        exp_an[0] = 3'b110; exp_an[1] = 3'b101; exp_an[2] = 3'b011;
        exp_seg[0] = so;    exp_seg[1] = st;    exp_seg[2] = sh;
        found = 0;
        prev  = an;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (prev == 3'b011 && an == 3'b110) found = 1;
            prev = an;
        end
        if (!found) begin
            chk("scan_align_timeout", 32'(an), 32'b110);
        end else begin
            for (int c = 0; c < 12; c++) begin
                if (an !== exp_an[c / 4] || seg !== exp_seg[c / 4]) begin
                    chk("scan_an_seg", {22'd0, an, seg}, {22'd0, exp_an[c / 4], exp_seg[c / 4]});
                end
                if (c % 4 == 0) begin
                    chk("scan_digit", {22'd0, an, seg}, {22'd0, exp_an[c / 4], exp_seg[c / 4]});
                end
                tick();
            end
        end
    endtask

    initial begin
        vecs[0] = '{8'd255, 12'h255, 7'b0100100, 7'b0010010, 7'b0010010};
        vecs[1] = '{8'd7,   12'h007, LZ,         LZ,         7'b1111000};
        vecs[2] = '{8'd48,  12'h048, LZ,         7'b0011001, 7'b0000000};
        vecs[3] = '{8'd199, 12'h199, 7'b1111001, 7'b0010000, 7'b0010000};
        vecs[4] = '{8'd90,  12'h090, LZ,         7'b0010000, 7'b1000000};

        // Reset
        rst   = 1'b1;
        value = 8'd0;
        tick();
        tick();
        chk("rst_seg", 32'(seg), 32'b1000000);
        chk("rst_an", 32'(an), 32'b110);
        chk("rst_bcd", 32'(bcd), 32'h000);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(bcd_valid), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("idle_busy_after_rst", 32'(busy), 32'd0);

        // Table-driven conversions and scan patterns
        for (int i = 0; i < 5; i++) begin
            convert(vecs[i].v, vecs[i].bcd);
            check_scan(vecs[i].seg_h, vecs[i].seg_t, vecs[i].seg_o);
        end

        // A few random values against the arithmetic model
        for (int i = 0; i < 3; i++) begin
            int v;
            v = int'($urandom_range(0, 255));
            if (v == int'(value)) v = (v + 1) % 256;
            convert(8'(v), model_bcd(v));
        end

        // Mid-conversion change: 100 completes, then 37 restarts
        value = 8'd100;
        exp_q.push_back(12'h100);
        tick();
        for (int i = 0; i < 3; i++) tick();
        value = 8'd37;
        exp_q.push_back(12'h037);
        begin
            bit done;
            done = 0;
            for (int i = 0; i < 40 && !done; i++) begin
                tick();
                if (exp_q.size() == 0 && busy == 1'b0) done = 1;
            end
            chk("midchange_done", 32'(done), 32'd1);
        end
        chk("midchange_bcd", 32'(bcd), 32'h037);

        // Reset in the middle of a conversion of 200
        value = 8'd200;
        tick();
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_bcd", 32'(bcd), 32'h000);
        chk("midrst_an", 32'(an), 32'b110);
        chk("midrst_seg", 32'(seg), 32'b1000000);
        chk("midrst_valid", 32'(bcd_valid), 32'd0);
        tick();
        rst = 1'b0;
        exp_q.push_back(12'h200);
        tick();
        chk("post_rst_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) tick();
        chk("post_rst_bcd", 32'(bcd), 32'h200);
        chk("post_rst_valid", 32'(bcd_valid), 32'd1);
        tick();
        check_scan(7'b0100100, 7'b1000000, 7'b1000000);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
